muldiv_seq: RTL and testbench

Multi-cycle sequencer for the RV64 M-extension, owned by the EX stage. It accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU or W-variant operation from the EX stage and iterates it one bit per cycle on an internal shift-add / restoring-divide datapath. While it works, it stalls the pipeline, then returns the 64-bit result together with the destination register. The single-cycle ALU keeps all non-M operations; this block replaces the MULW/DIVW/REMW/DIVUW/REMUW trap path.

---
 rtl/muldiv_seq.sv | 176 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV64 M-extension unit. Multiplies by shift-add and
// divides by restoring division, one bit per cycle. The pipeline is stalled
// while an operation iterates, and the result is returned with its rd.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [2:0]  funct3_i,
    input  logic        word_i,
    input  logic [63:0] operand1_i,
    input  logic [63:0] operand2_i,
    input  logic [4:0]  rd_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] result_o,
    output logic [4:0]  rd_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t       state_q, state_d;
    logic [5:0]   count_q;
    logic [2:0]   funct3_q;
    logic         word_q;
    logic         neg_q;       // negate product / quotient
    logic         neg_rem_q;   // negate remainder (sign of dividend)
    logic [4:0]   rd_q;
    logic [127:0] x_q;         // mul: shifting multiplicand; div: {remainder, quotient}
    logic [63:0]  y_q;         // mul: shifting multiplier;   div: divisor magnitude
    logic [127:0] p_q;         // mul: product accumulator

    // Operand preparation for the incoming op: extension, magnitudes, special cases
    logic         is_div, signed1, signed2, sign1, sign2, special;
    logic [63:0]  ext1, ext2, mag1, mag2, special_raw, special_res;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        is_div  = funct3_i[2];
        signed1 = is_div ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01 || funct3_i[1:0] == 2'b10);
        signed2 = is_div ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01);
        ext1    = operand1_i;
        ext2    = operand2_i;
        if (word_i) begin
            // DIVUW/REMUW zero-extend; MULW/DIVW/REMW sign-extend
            ext1 = funct3_i[0] ? {32'b0, operand1_i[31:0]} : {{32{operand1_i[31]}}, operand1_i[31:0]};
            ext2 = funct3_i[0] ? {32'b0, operand2_i[31:0]} : {{32{operand2_i[31]}}, operand2_i[31:0]};
        end
        sign1 = signed1 & ext1[63];
        sign2 = signed2 & ext2[63];
        mag1  = sign1 ? -ext1 : ext1;
        mag2  = sign2 ? -ext2 : ext2;

        special     = 1'b0;
        special_raw = '0;
        if (is_div && ext2 == '0) begin
            // Divide by zero: quotient all ones, remainder is the dividend
            special     = 1'b1;
            special_raw = funct3_i[1] ? ext1 : '1;
        end else if (is_div && !funct3_i[0] && ext2 == '1 &&
                     ext1 == (word_i ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) begin
            // Signed overflow: quotient is the dividend, remainder zero
            special     = 1'b1;
            special_raw = funct3_i[1] ? 64'd0 : ext1;
        end
        special_res = word_i ? {{32{special_raw[31]}}, special_raw[31:0]} : special_raw;
    end

    // One iteration of the shift-add multiplier or restoring divider
    logic [127:0] p_next, x_next;
    logic [63:0]  y_next;
    logic [64:0]  trial;

    always_comb begin
        p_next = p_q;
        x_next = x_q;
        y_next = y_q;
        trial  = '0;
        if (funct3_q[2]) begin
            // Shifted partial remainder (65 bits incl. carry-out) minus divisor
            trial = x_q[127:63] - {1'b0, y_q};
            if (!trial[64]) x_next = {trial[63:0], x_q[62:0], 1'b1};
            else            x_next = {x_q[126:0], 1'b0};
        end else begin
            if (y_q[0]) p_next = p_q + x_q;
            x_next = {x_q[126:0], 1'b0};
            y_next = {1'b0, y_q[63:1]};
        end
    end

    // Sign fix and result selection, taken from the final iteration's values
    logic [127:0] prod_s;
    logic [63:0]  quo_s, rem_s, raw, final_res;

    always_comb begin
        prod_s = neg_q ? -p_next : p_next;
        quo_s  = neg_q ? -x_next[63:0] : x_next[63:0];
        rem_s  = neg_rem_q ? -x_next[127:64] : x_next[127:64];
        case (funct3_q)
            3'b000:                 raw = prod_s[63:0];
            3'b001, 3'b010, 3'b011: raw = prod_s[127:64];
            3'b100, 3'b101:         raw = quo_s;
            default:                raw = rem_s;
        endcase
        final_res = word_q ? {{32{raw[31]}}, raw[31:0]} : raw;
    end

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and status outputs
    always_comb begin
        state_d = state_q;
        busy_o  = (state_q == CALC);
        done_o  = (state_q == DONE);
        stall_o = (state_q == CALC) || (state_q == IDLE && start_i);
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_i) state_d = special ? DONE : CALC;
                CALC:    if (count_q == 6'd0) state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Operand latching, iteration datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            funct3_q  <= '0;
            word_q    <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            rd_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            p_q       <= '0;
            result_o  <= '0;
            rd_o      <= '0;
        end else if (!flush_i) begin
            if (state_q == IDLE && start_i) begin
                funct3_q  <= funct3_i;
                word_q    <= word_i;
                neg_q     <= sign1 ^ sign2;
                neg_rem_q <= sign1;
                rd_q      <= rd_i;
                count_q   <= word_i ? 6'd31 : 6'd63;
                p_q       <= '0;
                y_q       <= mag2;
                // Word divides start with the 32-bit dividend in the upper quotient half
                x_q       <= (is_div && word_i) ? {64'b0, mag1[31:0], 32'b0} : {64'b0, mag1};
                if (special) begin
                    result_o <= special_res;
                    rd_o     <= rd_i;
                end
            end else if (state_q == CALC) begin
                p_q     <= p_next;
                x_q     <= x_next;
                y_q     <= y_next;
                count_q <= count_q - 6'd1;
                if (count_q == 6'd0) begin
                    result_o <= final_res;
                    rd_o     <= rd_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq: hand-computed vectors, latency and
// stall checks, back-to-back starts, flush and asynchronous reset.
module tb_muldiv_seq;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic        word_i;
    logic [63:0] operand1_i;
    logic [63:0] operand2_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [63:0] result_o;
    logic [4:0]  rd_o;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .funct3_i   (funct3_i),
        .word_i     (word_i),
        .operand1_i (operand1_i),
        .operand2_i (operand2_i),
        .rd_i       (rd_i),
        .flush_i    (flush_i),
        .stall_o    (stall_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .rd_o       (rd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] f3, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd);
        funct3_i   = f3;
        word_i     = w;
        operand1_i = a;
        operand2_i = b;
        rd_i       = rd;
        start_i    = 1'b1;
    endtask

    // Starts an op at the current negedge (or the next one when chained after
    // DONE), waits for done_o with a cycle bound and checks the outcome.
    task automatic run(input string tag, input logic [2:0] f3, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                       input logic [63:0] exp, input int exp_lat, input bit hold, input bit chain);
        int lat = 0;
        int stall_low = 0;
        drive(f3, w, a, b, rd);
        if (chain) @(negedge clk);
        #1;
        check({tag, "_stall0"}, 64'(stall_o), 64'd1);
        check({tag, "_done0"}, 64'(done_o), 64'd0);
        do begin
            @(negedge clk);
            lat++;
            if (!done_o && !stall_o) stall_low++;
            if (!hold) start_i = 1'b0;
        end while (!done_o && lat < 100);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, result_o, exp);
        check({tag, "_rd"}, 64'(rd_o), 64'(rd));
        check({tag, "_stall_done"}, 64'(stall_o), 64'd0);
        check({tag, "_stall_calc"}, 64'(stall_low), 64'd0);
        if (!hold) begin
            @(negedge clk);
            check({tag, "_pulse"}, 64'(done_o), 64'd0);
            check({tag, "_held"}, result_o, exp);
        end
    endtask

    initial begin
        int dones;
        rst        = 1'b1;
        start_i    = 1'b0;
        funct3_i   = '0;
        word_i     = 1'b0;
        operand1_i = '0;
        operand2_i = '0;
        rd_i       = '0;
        flush_i    = 1'b0;

        // Reset state
        #1;
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_result", result_o, 64'd0);
        check("rst_rd", 64'(rd_o), 64'd0);
        check("rst_stall_lo", 64'(stall_o), 64'd0);
        start_i = 1'b1;
        #1;
        check("rst_stall_hi", 64'(stall_o), 64'd1);
        start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 64-bit multiplies
        run("mul_neg", F_MUL, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd1, 64'hFFFF_FFFF_FFFF_FFF1, 65, 1'b0, 1'b0);
        run("mulhu", F_MULHU, 1'b0, '1, '1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b0, 1'b0);
        run("mulh", F_MULH, 1'b0, '1, '1, 5'd3, 64'd0, 65, 1'b0, 1'b0);

        // Divide special cases, latency 1
        run("div0", F_DIV, 1'b0, 64'd7, 64'd0, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0, 1'b0);
        run("rem0", F_REM, 1'b0, 64'd7, 64'd0, 5'd5, 64'd7, 1, 1'b0, 1'b0);
        run("div_ovf", F_DIV, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd6, 64'h8000_0000_0000_0000, 1, 1'b0, 1'b0);
        run("rem_ovf", F_REM, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd7, 64'd0, 1, 1'b0, 1'b0);

        // Word variants
        run("divuw", F_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd2, 5'd8, 64'h0000_0000_7FFF_FFFF, 33, 1'b0, 1'b0);
        run("remw", F_REM, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 33, 1'b0, 1'b0);
        run("mulw", F_MUL, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd10, 64'hFFFF_FFFF_FFFF_FFFE, 33, 1'b0, 1'b0);
        run("divw_ovf", F_DIV, 1'b1, 64'h0000_0000_8000_0000, '1, 5'd11, 64'hFFFF_FFFF_8000_0000, 1, 1'b0, 1'b0);

        // start_i held through DONE, then a new op in the first IDLE cycle
        run("hold", F_MUL, 1'b0, 64'd6, 64'd7, 5'd12, 64'd42, 65, 1'b1, 1'b0);
        run("b2b", F_MUL, 1'b0, 64'd100, 64'd3, 5'd13, 64'd300, 65, 1'b0, 1'b1);

        // Flush at CALC cycle 10
        drive(F_MULHU, 1'b0, 64'd5, 64'd5, 5'd3);
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_busy_before", 64'(busy_o), 64'd1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_busy_after", 64'(busy_o), 64'd0);
        check("flush_done", 64'(done_o), 64'd0);
        check("flush_result", result_o, 64'd300);
        check("flush_rd", 64'(rd_o), 64'd13);
        dones = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        check("flush_no_done", 64'(dones), 64'd0);

        // Flush wins over start in IDLE
        drive(F_DIVU, 1'b0, 64'd9, 64'd3, 5'd1);
        flush_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        flush_i = 1'b0;
        check("flush_prio_busy", 64'(busy_o), 64'd0);
        check("flush_prio_result", result_o, 64'd300);

        run("divu", F_DIVU, 1'b0, 64'd100, 64'd7, 5'd14, 64'd14, 65, 1'b0, 1'b0);
        run("remu", F_REMU, 1'b0, 64'd100, 64'd7, 5'd15, 64'd2, 65, 1'b0, 1'b0);

        // Asynchronous reset between edges during CALC
        drive(F_MUL, 1'b0, 64'd5, 64'd5, 5'd20);
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", 64'(busy_o), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 64'(busy_o), 64'd0);
        check("async_rst_done", 64'(done_o), 64'd0);
        check("async_rst_result", result_o, 64'd0);
        check("async_rst_rd", 64'(rd_o), 64'd0);
        check("async_rst_stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run("mulhsu", F_MULHSU, 1'b0, '1, 64'd2, 5'd16, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
